clock_enable_recovery: RTL and testbench



---
 rtl/clock_enable_recovery_pkg.sv | 16 +
 rtl/clock_enable_recovery_sync_edge_detect.sv | 37 +++
 rtl/clock_enable_recovery.sv | 117 +++++++++++
 tb/tb_clock_enable_recovery.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_enable_recovery_pkg.sv
// Shared state type and default constants for recovering clock enables
// from an asynchronous external clock or strobe.
package clock_enable_pkg;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2
  } cer_state_t;

  localparam int CER_CNT_W      = 16;
  localparam int CER_TIMEOUT    = 65535;
  localparam int CER_TOL        = 1;
  localparam int CER_LOCK_COUNT = 4;

endpackage

// File: rtl/clock_enable_recovery_sync_edge_detect.sv
// Two-flop synchronizer plus an edge flop for any asynchronous level input;
// emits registered one-cycle rise/fall enables in the clk domain.
module sync_edge_detect (
  input  logic clk,
  input  logic nrst,
  input  logic async_in,
  output logic rise_en,
  output logic fall_en
);

  // sync_q[0] is the metastability catcher; [1] and [2] are settled history.
  logic [2:0] sync_q, sync_d;
  logic       rise_q, rise_d;
  logic       fall_q, fall_d;

  always_comb begin
    sync_d = {sync_q[1:0], async_in};
    rise_d = sync_q[1] & ~sync_q[2];
    fall_d = ~sync_q[1] & sync_q[2];
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      sync_q <= '0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise_en = rise_q;
  assign fall_en = fall_q;

endmodule

// File: rtl/clock_enable_recovery.sv
// Recovers rise/fall enables from an external clock, measures its period
// and tracks lock / loss-of-input.
module clock_enable_recovery
  import clock_enable_pkg::*;
#(
  parameter int CNT_W      = CER_CNT_W,
  parameter int TOL        = CER_TOL,
  parameter int LOCK_COUNT = CER_LOCK_COUNT,
  parameter int TIMEOUT    = CER_TIMEOUT
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             ext_clk,
  output logic             rise_en,
  output logic             fall_en,
  output logic [CNT_W-1:0] period,
  output logic             locked,
  output logic             timeout
);

  localparam int                 MATCH_W    = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0]   CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]   CNT_TO     = CNT_W'(TIMEOUT);
  localparam logic [CNT_W:0]     TOL_W      = (CNT_W + 1)'(TOL);
  localparam logic [MATCH_W-1:0] MATCH_FULL = MATCH_W'(LOCK_COUNT);

  logic rise_w, fall_w;

  sync_edge_detect u_sync (
    .clk      (clk),
    .nrst     (nrst),
    .async_in (ext_clk),
    .rise_en  (rise_w),
    .fall_en  (fall_w)
  );

  cer_state_t         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   period_q, period_d;
  logic [MATCH_W-1:0] match_q, match_d;
  logic               timeout_q, timeout_d;
  logic               expired_q, expired_d;

  logic [CNT_W-1:0]    measured;
  logic signed [CNT_W:0] diff;
  logic [CNT_W:0]      abs_diff;
  logic                in_tol;

  // One extra bit keeps the signed difference of two unsigned periods exact.
  always_comb begin
    measured = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;
    diff     = $signed({1'b0, measured}) - $signed({1'b0, period_q});
    abs_diff = diff[CNT_W] ? $unsigned(-diff) : $unsigned(diff);
    in_tol   = (period_q != '0) && (abs_diff <= TOL_W);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    period_d  = period_q;
    match_d   = match_q;
    timeout_d = 1'b0;
    expired_d = expired_q;

    if (rise_w) begin
      cnt_d     = '0;
      expired_d = 1'b0;
      if (state_q == UNLOCKED) begin
        state_d = ACQUIRE;
      end else begin
        period_d = measured;
        if (in_tol) begin
          match_d = (match_q == MATCH_FULL) ? match_q : match_q + 1'b1;
        end else begin
          match_d = '0;
        end
        case (state_q)
          ACQUIRE: if (match_d == MATCH_FULL) state_d = LOCKED;
          LOCKED:  if (!in_tol) state_d = ACQUIRE;
          default: state_d = state_q;
        endcase
      end
    // expired_q stops a repeat when TIMEOUT equals the saturation value.
    end else if ((cnt_q == CNT_TO) && !expired_q) begin
      timeout_d = 1'b1;
      expired_d = 1'b1;
      period_d  = '0;
      match_d   = '0;
      state_d   = UNLOCKED;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q   <= UNLOCKED;
      cnt_q     <= '0;
      period_q  <= '0;
      match_q   <= '0;
      timeout_q <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      match_q   <= match_d;
      timeout_q <= timeout_d;
      expired_q <= expired_d;
    end
  end

  assign rise_en = rise_w;
  assign fall_en = fall_w;
  assign period  = period_q;
  assign locked  = (state_q == LOCKED);
  assign timeout = timeout_q;

endmodule

// File: tb/tb_clock_enable_recovery.sv
// Randomized and directed stimulus for clock_enable_recovery, checked every
// cycle against an event-based reference model of the recovery rules.
module tb_clock_enable_recovery;

  localparam int CNT_W      = 8;
  localparam int TOL        = 1;
  localparam int LOCK_COUNT = 3;
  localparam int TIMEOUT    = 200;
  localparam int CNT_MAX    = 255;

  logic             clk = 1'b0;
  logic             nrst = 1'b0;
  logic             ext_clk = 1'b0;
  logic             rise_en, fall_en, locked, timeout;
  logic [CNT_W-1:0] period;

  clock_enable_recovery #(
    .CNT_W      (CNT_W),
    .TOL        (TOL),
    .LOCK_COUNT (LOCK_COUNT),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk     (clk),
    .nrst    (nrst),
    .ext_clk (ext_clk),
    .rise_en (rise_en),
    .fall_en (fall_en),
    .period  (period),
    .locked  (locked),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int edge_n = 0;

  // Reference model: edges become scheduled events; the counter is the
  // distance from the last clearing edge; states 0/1/2 = unlocked/acquire/locked.
  int q_rise[$];
  int q_fall[$];
  int prev_samp, clr_edge, m_state, m_period, m_match;
  bit m_rise, m_fall, m_timeout;

  int n_rises = 0, n_falls = 0, n_timeouts = 0;
  int last_rise_cyc = 0, last_fall_cyc = 0, last_to_cyc = 0;
  int rise_base = 0, lock_gain_rises = -1;
  bit locked_prev = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, edge_n);
    end
  endtask

  task automatic model_reset();
    q_rise.delete();
    q_fall.delete();
    prev_samp = 0;
    clr_edge  = edge_n;
    m_state   = 0;
    m_period  = 0;
    m_match   = 0;
    m_rise    = 1'b0;
    m_fall    = 1'b0;
    m_timeout = 1'b0;
  endtask

  task automatic model_step();
    int cnt, meas, diff;
    bit ok, r_now, f_now;
    edge_n++;
    if (!nrst) begin
      model_reset();
      return;
    end
    if (ext_clk && prev_samp == 0) q_rise.push_back(edge_n + 2);
    if (!ext_clk && prev_samp == 1) q_fall.push_back(edge_n + 2);
    prev_samp = ext_clk ? 1 : 0;
    cnt = (edge_n - 1) - clr_edge;
    if (cnt > CNT_MAX) cnt = CNT_MAX;
    m_timeout = 1'b0;
    if (m_rise) begin
      clr_edge = edge_n;
      meas = (cnt + 1 > CNT_MAX) ? CNT_MAX : cnt + 1;
      if (m_state == 0) begin
        m_state = 1;
      end else begin
        diff = meas - m_period;
        if (diff < 0) diff = -diff;
        ok = (m_period != 0) && (diff <= TOL);
        m_period = meas;
        m_match = ok ? ((m_match + 1 > LOCK_COUNT) ? LOCK_COUNT : m_match + 1) : 0;
        if (m_state == 1 && m_match == LOCK_COUNT) m_state = 2;
        else if (m_state == 2 && !ok) m_state = 1;
      end
    end else if (cnt == TIMEOUT) begin
      m_timeout = 1'b1;
      m_period  = 0;
      m_match   = 0;
      m_state   = 0;
    end
    r_now = (q_rise.size() > 0) && (q_rise[0] == edge_n);
    if (r_now) void'(q_rise.pop_front());
    f_now = (q_fall.size() > 0) && (q_fall[0] == edge_n);
    if (f_now) void'(q_fall.pop_front());
    m_rise = r_now;
    m_fall = f_now;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_eq("rise_en", rise_en, m_rise);
    check_eq("fall_en", fall_en, m_fall);
    check_eq("period",  period, m_period);
    check_eq("locked",  locked, (m_state == 2));
    check_eq("timeout", timeout, m_timeout);
    if (rise_en === 1'b1) begin
      n_rises++;
      last_rise_cyc = edge_n;
      $display("rise    cycle %0d period %0d locked %0b", edge_n, period, locked);
    end
    if (fall_en === 1'b1) begin
      n_falls++;
      last_fall_cyc = edge_n;
    end
    if (timeout === 1'b1) begin
      n_timeouts++;
      last_to_cyc = edge_n;
      $display("timeout cycle %0d", edge_n);
    end
    if (locked === 1'b1 && !locked_prev) lock_gain_rises = n_rises - rise_base;
    locked_prev = (locked === 1'b1);
  endtask

  task automatic ext_period(input int hi, input int lo);
    ext_clk = 1'b1;
    repeat (hi) tick();
    ext_clk = 1'b0;
    repeat (lo) tick();
  endtask

  task automatic wait_rise(input string tag, input int limit, output int used);
    used = 0;
    do begin
      tick();
      used++;
    end while (rise_en !== 1'b1 && used < limit);
    check_eq(tag, rise_en, 1'b1);
  endtask

  initial begin
    int used, base_to, p, hi, base_p, sel;

    // Reset held with ext_clk high; first rise 3 cycles after release.
    ext_clk = 1'b1;
    nrst = 1'b0;
    repeat (5) tick();
    check_eq("rst_period", period, 0);
    check_eq("rst_locked", locked, 0);
    nrst = 1'b1;
    wait_rise("rise_after_release", 20, used);
    check_eq("release_latency", used, 3);
    tick();
    check_eq("release_locked", locked, 0);

    // Fresh start, period 10 (5/5): lock the cycle after the 5th rise.
    ext_clk = 1'b0;
    nrst = 1'b0;
    repeat (3) tick();
    nrst = 1'b1;
    rise_base = n_rises;
    lock_gain_rises = -1;
    repeat (6) ext_period(5, 5);
    check_eq("p10_period", period, 10);
    check_eq("p10_locked", locked, 1);
    check_eq("p10_lock_rises", lock_gain_rises, 5);
    check_eq("p10_rise_fall_gap", last_fall_cyc - last_rise_cyc, 5);

    // Jitter within TOL keeps lock; a 14 breaks it; 4 more periods relock.
    ext_period(5, 6);
    ext_period(5, 5);
    ext_period(5, 4);
    ext_period(5, 5);
    ext_period(7, 7);
    check_eq("jitter_locked", locked, 1);
    ext_clk = 1'b1;
    wait_rise("rise_after_14", 10, used);
    tick();
    check_eq("p14_period", period, 14);
    check_eq("p14_locked", locked, 0);
    repeat (5 - used - 1) tick();
    ext_clk = 1'b0;
    repeat (5) tick();
    repeat (3) ext_period(5, 5);
    check_eq("relock_early", locked, 0);
    ext_period(5, 5);
    check_eq("relock", locked, 1);

    // Idle input: one timeout, TIMEOUT+2 cycles after the last rise enable
    // (counter restarts the cycle after rise_en, output is registered).
    base_to = n_timeouts;
    ext_clk = 1'b0;
    repeat (450) tick();
    check_eq("idle_timeouts", n_timeouts - base_to, 1);
    check_eq("timeout_gap", last_to_cyc - last_rise_cyc, TIMEOUT + 2);
    check_eq("idle_period", period, 0);
    check_eq("idle_locked", locked, 0);

    // Minimum period 4: every edge pulses, lock at period 4.
    rise_base = n_rises;
    base_p = n_falls;
    repeat (8) ext_period(2, 2);
    tick();
    check_eq("p4_rises", n_rises - rise_base, 8);
    check_eq("p4_falls", n_falls - base_p, 8);
    check_eq("p4_period", period, 4);
    check_eq("p4_locked", locked, 1);

    // A rise landing exactly on cnt == TIMEOUT wins over the timeout.
    base_to = n_timeouts;
    ext_period(2, TIMEOUT - 1);
    ext_clk = 1'b1;
    wait_rise("rise_on_timeout", 10, used);
    tick();
    check_eq("edge_timeouts", n_timeouts - base_to, 0);
    check_eq("edge_period", period, TIMEOUT + 1);
    ext_clk = 1'b0;
    repeat (5) tick();

    // One-cycle reset while locked at 10, then reacquire in 5 rises.
    repeat (6) ext_period(5, 5);
    check_eq("pre_rst_locked", locked, 1);
    ext_clk = 1'b1;
    repeat (5) tick();
    ext_clk = 1'b0;
    nrst = 1'b0;
    tick();
    nrst = 1'b1;
    check_eq("midrst_period", period, 0);
    check_eq("midrst_locked", locked, 0);
    repeat (4) tick();
    repeat (4) ext_period(5, 5);
    check_eq("reacq_early", locked, 0);
    ext_period(5, 5);
    check_eq("reacq_locked", locked, 1);

    // Random periods, jitter, idles and reset pulses.
    base_p = 10;
    for (int it = 0; it < 120; it++) begin
      if (it % 15 == 0) base_p = $urandom_range(4, 40);
      sel = $urandom_range(0, 19);
      if (sel == 0) begin
        ext_clk = $urandom_range(0, 1);
        nrst = 1'b0;
        repeat ($urandom_range(1, 3)) tick();
        nrst = 1'b1;
      end else if (sel == 1) begin
        ext_clk = 1'b0;
        repeat ($urandom_range(150, 260)) tick();
      end else begin
        p = base_p + $urandom_range(0, 2) - 1;
        if (p < 4) p = 4;
        hi = $urandom_range(2, p - 2);
        ext_period(hi, p - hi);
      end
    end
    ext_clk = 1'b0;
    repeat (10) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
